// File: rtl/pipe_if_buf.sv
// Instruction-fetch stage: fetch PC, synchronous IMEM with one-cycle read,
// 2-entry output buffer absorbing decode stalls, redirect flush, and a
// program-load write port that leaves the PC untouched.
module pipe_if_buf #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [1:0]        pcsource,
  input  logic [31:0]       pc_jr,
  input  logic [31:0]       br_base,
  input  logic [17:0]       imm18,
  input  logic [27:0]       index28,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic              if_valid,
  output logic [31:0]       if_inst,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_pc4,
  output logic [31:0]       if_pc8
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] pc8;
  } entry_t;

  logic [31:0] mem [2**ADDR_W];
  logic [31:0] rd_data_reg;
  logic [31:0] fpc_reg;
  logic [31:0] tag_reg;
  logic        inflight_reg;
  logic [1:0]  count_reg;
  logic [1:0]  count_next;
  entry_t      entry_reg  [2];
  entry_t      entry_next [2];

  logic        redir;
  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occupancy;
  logic [1:0]  count_after_pop;
  logic [31:0] target;
  entry_t      new_entry;

  // A redirect with pcsource 00 is treated as no redirect at all.
  assign redir = redirect && (pcsource != 2'b00);
  assign pop   = (count_reg != 2'd0) && !stall;
  assign push  = inflight_reg;

  // Credit check: buffered + in-flight entries after this cycle's pop must leave room.
  assign occupancy       = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign issue           = !rst && !redir && !ld_we && (occupancy < 3'd2);
  assign count_after_pop = count_reg - {1'b0, pop};

  // Redirect target selection.
  always_comb begin
    target = pc_jr;
    case (pcsource)
      2'b01:   target = pc_jr;
      2'b10:   target = br_base + {{14{imm18[17]}}, imm18};
      2'b11:   target = {br_base[31:28], index28};
      default: target = pc_jr;
    endcase
  end

  // Returning read data with its tag; successor PCs are precomputed here.
  always_comb begin
    new_entry.inst = rd_data_reg;
    new_entry.pc   = tag_reg;
    new_entry.pc4  = tag_reg + 32'd4;
    new_entry.pc8  = tag_reg + 32'd8;
  end

  // Instruction RAM: load-port write and registered fetch read.
  always_ff @(posedge clk) begin
    if (ld_we && !rst) begin
      mem[ld_addr] <= ld_data;
    end
    if (issue) begin
      rd_data_reg <= mem[fpc_reg[ADDR_W+1:2]];
    end
  end

  // Fetch PC, tag and in-flight flag; a redirect discards any in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_reg      <= RESET_PC;
      tag_reg      <= 32'd0;
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        tag_reg <= fpc_reg;
      end
      if (redir) begin
        fpc_reg <= target;
      end else if (issue) begin
        fpc_reg <= fpc_reg + 32'd4;
      end
    end
  end

  // Buffer next-state: shift head out on pop, then append returning data at the tail.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      entry_next[i] = entry_reg[i];
    end
    if (pop) begin
      entry_next[0] = entry_reg[1];
    end
    if (push) begin
      for (int i = 0; i < 2; i++) begin
        if (count_after_pop == 2'(i)) begin
          entry_next[i] = new_entry;
        end
      end
    end
    count_next = count_after_pop + {1'b0, push};
  end

  // Buffer registers; a redirect empties the buffer and drops returning data.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        entry_reg[i] <= '0;
      end
    end else if (redir) begin
      count_reg <= 2'd0;
    end else begin
      count_reg <= count_next;
      for (int i = 0; i < 2; i++) begin
        entry_reg[i] <= entry_next[i];
      end
    end
  end

  assign if_valid = (count_reg != 2'd0);
  assign if_inst  = entry_reg[0].inst;
  assign if_pc    = entry_reg[0].pc;
  assign if_pc4   = entry_reg[0].pc4;
  assign if_pc8   = entry_reg[0].pc8;

endmodule

// File: tb/tb_pipe_if_buf.sv
// Bench for pipe_if_buf: a queue of expected fetch addresses is refilled by
// the stimulus on every control transfer; a monitor pops one entry for every
// instruction decode accepts and compares it against a memory model.
module tb_pipe_if_buf;
  localparam int          ADDR_W   = 10;
  localparam int          DEPTH    = 2**ADDR_W;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stall = 1'b0;
  logic              redirect = 1'b0;
  logic [1:0]        pcsource = 2'b00;
  logic [31:0]       pc_jr = '0;
  logic [31:0]       br_base = '0;
  logic [17:0]       imm18 = '0;
  logic [27:0]       index28 = '0;
  logic              ld_we = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [31:0]       ld_data = '0;
  logic              if_valid;
  logic [31:0]       if_inst, if_pc, if_pc4, if_pc8;

  pipe_if_buf #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .pcsource(pcsource),
    .pc_jr(pc_jr), .br_base(br_base), .imm18(imm18), .index28(index28),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_pc4(if_pc4), .if_pc8(if_pc8)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_at(input logic [31:0] pc);
    return model_mem[(pc >> 2) % DEPTH];
  endfunction

  // Expected architectural stream from a new start address.
  task automatic restart_stream(input logic [31:0] start);
    exp_q.delete();
    for (int k = 0; k < 512; k++) exp_q.push_back(start + 32'(4 * k));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: one line per accepted instruction, plus hold check while stalled.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_pc, prev_inst;
  always @(negedge clk) begin
    logic [31:0] e;
    logic        eff_redir;
    eff_redir = redirect && (pcsource != 2'b00);
    if (!rst && prev_hold && if_valid) begin
      chk("stall_hold_pc", if_pc, prev_pc);
      chk("stall_hold_inst", if_inst, prev_inst);
    end
    if (!rst && !eff_redir && if_valid && !stall) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", if_pc, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        $display("accept pc=%h inst=%h", if_pc, if_inst);
        chk("stream_pc", if_pc, e);
        chk("stream_inst", if_inst, mem_at(e));
        chk("stream_pc4", if_pc4, e + 32'd4);
        chk("stream_pc8", if_pc8, e + 32'd8);
      end
    end
    prev_hold = !rst && !eff_redir && if_valid && stall;
    prev_pc   = if_pc;
    prev_inst = if_inst;
  end

  // Drive a redirect in cycle N and check the N+1..N+3 timeline.
  task automatic do_redirect(input logic [1:0] src, input logic [31:0] jr, input logic [31:0] br,
                             input logic [17:0] imm, input logic [27:0] idx, input logic stl);
    logic [31:0] tgt;
    case (src)
      2'b01:   tgt = jr;
      2'b10:   tgt = br + 32'($signed(imm));
      default: tgt = {br[31:28], idx};
    endcase
    step();
    redirect = 1'b1; pcsource = src; pc_jr = jr; br_base = br; imm18 = imm; index28 = idx;
    stall = stl;
    restart_stream(tgt);
    @(negedge clk);
    step();
    redirect = 1'b0; stall = 1'b0;
    @(negedge clk);
    chk("redir_n1_valid", {31'd0, if_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("redir_n2_valid", {31'd0, if_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("redir_n3_valid", {31'd0, if_valid}, 32'd1);
    chk("redir_n3_pc", if_pc, tgt);
    chk("redir_n3_inst", if_inst, mem_at(tgt));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    logic [31:0] held_pc;
    // Reset state.
    run(2);
    @(negedge clk);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_inst", if_inst, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_pc4", if_pc4, 32'd0);
    chk("rst_pc8", if_pc8, 32'd0);

    // Load the whole IMEM with random words through the load port.
    step();
    rst = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      ld_we = 1'b1; ld_addr = ADDR_W'(a); ld_data = $urandom;
      model_mem[a] = ld_data;
      step();
    end
    ld_we = 1'b0;
    rst = 1'b1;
    step();

    // Release reset: cycle 0 here, first valid in cycle 2.
    restart_stream(RESET_PC);
    rst = 1'b0;
    @(negedge clk);
    chk("start_c0_valid", {31'd0, if_valid}, 32'd0);
    step(); @(negedge clk);
    chk("start_c1_valid", {31'd0, if_valid}, 32'd0);
    step(); @(negedge clk);
    chk("start_c2_valid", {31'd0, if_valid}, 32'd1);
    chk("start_c2_pc", if_pc, RESET_PC);
    chk("start_c2_pc8", if_pc8, RESET_PC + 32'd8);
    run(3);

    // Stall for 4 cycles mid-stream.
    stall = 1'b1;
    @(negedge clk);
    held_pc = if_pc;
    run(4);
    @(negedge clk);
    chk("stall4_pc", if_pc, held_pc);
    stall = 1'b0;
    run(4);

    // Branch back to 0x08, jump into high memory, jr while stalled.
    do_redirect(2'b10, 32'd0, 32'h10, 18'h3FFF8, 28'd0, 1'b0);
    run(5);
    do_redirect(2'b11, 32'd0, 32'hA000_0004, 18'd0, 28'h000_0040, 1'b0);
    run(3);
    stall = 1'b1;
    run(3);
    do_redirect(2'b01, 32'h44, 32'd0, 18'd0, 28'd0, 1'b1);
    run(3);

    // Load words 5,6,7 mid-stream, then fetch them back.
    for (int a = 5; a < 8; a++) begin
      ld_we = 1'b1; ld_addr = ADDR_W'(a); ld_data = $urandom;
      model_mem[a] = ld_data;
      step();
    end
    ld_we = 1'b0;
    run(6);
    do_redirect(2'b01, 32'h14, 32'd0, 18'd0, 28'd0, 1'b0);
    run(4);

    // Reset with the buffer full.
    stall = 1'b1;
    run(3);
    rst = 1'b1; stall = 1'b0;
    restart_stream(RESET_PC);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", {31'd0, if_valid}, 32'd0);
    chk("midrst_pc", if_pc, 32'd0);
    step(); @(negedge clk);
    chk("midrst_c2_valid", {31'd0, if_valid}, 32'd0);
    step(); @(negedge clk);
    chk("midrst_c3_valid", {31'd0, if_valid}, 32'd1);
    chk("midrst_c3_pc", if_pc, RESET_PC);
    chk("midrst_c3_inst", if_inst, mem_at(RESET_PC));

    // Random stalls and redirects.
    for (int k = 0; k < 400; k++) begin
      step();
      stall = ($urandom_range(9) < 3);
      if ($urandom_range(19) == 0) begin
        logic [31:0] tgt;
        redirect = 1'b1;
        pcsource = 2'($urandom_range(3, 1));
        pc_jr = $urandom; br_base = $urandom; imm18 = 18'($urandom); index28 = 28'($urandom);
        case (pcsource)
          2'b01:   tgt = pc_jr;
          2'b10:   tgt = br_base + 32'($signed(imm18));
          default: tgt = {br_base[31:28], index28};
        endcase
        restart_stream(tgt);
      end else begin
        redirect = 1'b0;
      end
    end
    step();
    redirect = 1'b0; stall = 1'b0;
    run(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_if_buf.md
Name: pipe_if_buf

Overview:
- Parametrised instruction-fetch stage, the successor to the current IF stage.
- Owns the fetch PC register and a synchronous instruction RAM with 1-cycle read latency.
- Absorbs decode back-pressure in a 2-entry output buffer and supports flush-on-redirect for jr, branch and jump.
- Adds a separate program-load write port so IMEM can be written without disturbing the PC.

Parameters:
- ADDR_W, 10, IMEM word-address bits; depth = 2**ADDR_W words, indexed by pc[ADDR_W+1:2].
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  decode not ready; the buffer head is held.
- redirect  in  1  control-transfer request from ID, valid this cycle.
- pcsource  in  2  target select: 01 jr, 10 branch, 11 jump; 00 with redirect=1 is ignored.
- pc_jr  in  32  jr target.
- br_base  in  32  pc+4 of the branching instruction.
- imm18  in  18  branch byte offset, sign-extended to 32 bits.
- index28  in  28  jump byte index.
- ld_we  in  1  program-load write enable.
- ld_addr  in  ADDR_W  program-load word address.
- ld_data  in  32  program-load word.
- if_valid  out  1  if_inst/if_pc/if_pc4/if_pc8 hold a valid instruction.
- if_inst  out  32  fetched instruction.
- if_pc  out  32  address of if_inst.
- if_pc4  out  32  if_pc+4.
- if_pc8  out  32  if_pc+8.

Behaviour:
- Reset: fetch PC fpc=RESET_PC; buffer count=0; in-flight flag=0; if_valid=0; if_inst, if_pc, if_pc4, if_pc8 = 0. IMEM contents are preserved. Reset mid-operation drops all buffered and in-flight fetches.
- Issue condition: !rst && !redirect && !ld_we && (count + inflight - pop) < 2, where pop = if_valid && !stall.
- On issue:
  - Read IMEM at fpc[ADDR_W+1:2].
  - Record fpc as the tag; inflight=1.
  - fpc <= fpc+4, using 32-bit wrap.
  - pc[1:0] is ignored.
  - Addresses beyond the depth alias modulo 2**ADDR_W.
- Data return: one cycle after issue, RAM data plus tag are written into the buffer tail; inflight clears unless a new issue occurs.
- Buffer:
  - 2-entry FIFO; the head drives the outputs as registers.
  - if_pc4 and if_pc8 are computed as tag+4 and tag+8 when the entry is written.
  - Head holds while stall=1.
  - A pop and a push in the same cycle keep count unchanged.
- Latency: issue in cycle N -> if_valid in cycle N+2. With stall=0, throughput is 1 instruction/cycle. The credit rule guarantees no overflow.
- Redirect (cycle N):
  - Buffer is flushed and the in-flight read is discarded; its data is never written.
  - if_valid=0 from N+1.
  - fpc <= target, where the target is:
    - jr: pc_jr.
    - branch: br_base + sign-extended imm18.
    - jump: {br_base[31:28], index28}.
  - First issue at the target occurs in N+1; its if_valid is in N+3.
- Simultaneous events:
  - redirect with stall: redirect wins and the buffer is flushed.
  - redirect with ld_we: both take effect; issue resumes once ld_we drops.
  - rst overrides everything.
- Load port:
  - ld_we writes ld_data at ld_addr on the edge and blocks issue that cycle.
  - An already in-flight read completes normally.
  - A read and write to the same word in the same cycle cannot occur, because issue is blocked.

Test Plan:
- Preload IMEM[0..3]=A,B,C,D; release rst at cycle 0 with stall=0 -> if_valid first high in cycle 2 with if_pc=0, inst=A, if_pc8=8; then B, C, D on consecutive cycles.
- Assert stall for 4 cycles while streaming -> if_inst/if_pc frozen on one entry; at most 2 entries buffered; after release the sequence continues with no gap or duplicate.
- Redirect with pcsource=10, br_base=0x10, imm18=0x3FFF8 -> target 0x08; no wrong-path instruction is emitted; next if_valid is 3 cycles after redirect with if_pc=0x08.
- Redirect with jump, br_base=0xA0000004, index28=0x0000040 -> if_pc=0xA0000040; redirect with jr, pc_jr=0x44 while stall=1 -> buffer flushed and if_pc=0x44.
- ld_we held 3 cycles mid-stream writing words 5,6,7 -> fetch pauses, then resumes at the correct PC; a later fetch of address 0x14 returns the loaded data.
- Assert rst mid-stream with buffer full -> if_valid=0 on the next cycle; refetch starts at RESET_PC; IMEM contents unchanged.
